// File: rtl/ee465_pkg.sv
// ee465_pkg
//   Constants and encodings shared by the 4-ASK symbol source and the
//   4x-oversampled pulse-shaping FIR.
//   - CLKS_PER_SAM / SAMS_PER_SYM : default enable ratios
//   - LFSR_SEED                   : default PRBS reset state (non-zero)
//   - LEVEL_A / LEVEL_3A          : 4-ASK amplitudes in 1s17
//   - mode_t                      : source mode encodings driven by sw
//   - SYM_*                       : Gray-coded symbol indices
//   - gray_level()                : symbol index to 1s17 amplitude
package ee465_pkg;

   localparam int CLKS_PER_SAM = 4;
   localparam int SAMS_PER_SYM = 4;

   localparam logic [21:0] LFSR_SEED = 22'h000001;

   localparam logic signed [17:0] LEVEL_A  = 18'sd16384;
   localparam logic signed [17:0] LEVEL_3A = LEVEL_A * 18'sd3;

   typedef enum logic [1:0] {
      MODE_PRBS  = 2'b00,
      MODE_CONST = 2'b01,
      MODE_ALT   = 2'b10,
      MODE_IMP   = 2'b11
   } mode_t;

   // Gray code: adjacent amplitudes differ in exactly one bit.
   localparam logic [1:0] SYM_M3A = 2'b00;
   localparam logic [1:0] SYM_M1A = 2'b01;
   localparam logic [1:0] SYM_P1A = 2'b11;
   localparam logic [1:0] SYM_P3A = 2'b10;

   function automatic logic signed [17:0] gray_level(input logic [1:0] sym,
                                                     input logic signed [17:0] lvl_a,
                                                     input logic signed [17:0] lvl_3a);
      logic signed [17:0] lvl;
      lvl = lvl_3a;
      unique case (sym)
         SYM_M3A: lvl = -lvl_3a;
         SYM_M1A: lvl = -lvl_a;
         SYM_P1A: lvl = lvl_a;
         SYM_P3A: lvl = lvl_3a;
      endcase
      return lvl;
   endfunction

endpackage

// File: rtl/prbs_lfsr22.sv
// prbs_lfsr22
//   22-bit Fibonacci LFSR, polynomial x^22 + x^21 + 1 (period 2^22-1).
//   Shifts left one step per advance; the new LSB is state[21]^state[20].
//   An all-zero state (the lock-up state) is forced back to 22'h000001.
// Ports
//   clk     in   system clock
//   reset   in   asynchronous, active-high; loads SEED
//   advance in   step the register once on this clock edge
//   state   out  current 22-bit register contents
module prbs_lfsr22
   import ee465_pkg::*;
#(
   parameter logic [21:0] SEED = LFSR_SEED
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        advance,
   output logic [21:0] state
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= SEED;
      end else if (state == 22'h000000) begin
         state <= 22'h000001;
      end else if (advance) begin
         state <= {state[20:0], state[21] ^ state[20]};
      end
   end

endmodule

// File: rtl/ask4_symbol_source.sv
// ask4_symbol_source
//   Stimulus stage for the time-shared pulse-shaping FIR. Produces the
//   sample enable (one per CLKS_PER_SAM clk) and symbol enable (every
//   SAMS_PER_SYM-th sample enable), draws 2-bit symbols from a PRBS or a
//   test pattern, Gray-maps them to 4-ASK levels and zero-stuffs the result
//   to the sample rate.
// Ports
//   clk         in   system clock
//   reset       in   asynchronous, active-high
//   sw          in   mode select: 00 PRBS, 01 const +3a, 10 alt +3a/-3a, 11 impulse
//   sam_clk_en  out  one-clk pulse per sample
//   sym_clk_en  out  one-clk pulse coincident with the last sample enable of a symbol
//   x_out       out  signed 1s17 zero-stuffed symbol stream (filter x_in)
//   sym_out     out  symbol index of the symbol currently in flight
// Handshake: none; the downstream FIR consumes x_out on the edge where it
// sees sam_clk_en high, and x_out is stable for the whole sample period.
module ask4_symbol_source
   import ee465_pkg::*;
#(
   parameter int                 CLKS_PER_SAM_P = CLKS_PER_SAM,
   parameter int                 SAMS_PER_SYM_P = SAMS_PER_SYM,
   parameter logic [21:0]        LFSR_SEED_P    = LFSR_SEED,
   parameter logic signed [17:0] LEVEL_A_P      = LEVEL_A
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         sw,
   output logic               sam_clk_en,
   output logic               sym_clk_en,
   output logic signed [17:0] x_out,
   output logic [1:0]         sym_out
);

   localparam int CW = (CLKS_PER_SAM_P > 1) ? $clog2(CLKS_PER_SAM_P) : 1;
   localparam int SW = (SAMS_PER_SYM_P > 1) ? $clog2(SAMS_PER_SYM_P) : 1;
   localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_SAM_P - 1);
   localparam logic [SW-1:0] SAM_LAST = SW'(SAMS_PER_SYM_P - 1);
   localparam logic signed [17:0] LEVEL_3A_P = LEVEL_A_P * 18'sd3;

   logic [CW-1:0] clk_cnt;
   logic [SW-1:0] sam_cnt;
   logic          clk_last;
   logic          sam_last;

   mode_t         mode;
   mode_t         sym_mode;
   logic          impulse_done;
   logic          alt_phase;

   logic [21:0]   lfsr_state;
   logic          lfsr_adv;
   logic [1:0]    prbs_sym;
   logic [1:0]    sym_sel;
   logic          level_zero;

   assign clk_last = (clk_cnt == CLK_LAST);
   assign sam_last = (sam_cnt == SAM_LAST);

   // Enables are registered so they are glitch-free one-clk pulses. The
   // pulse appears in the cycle after the counter reaches its last value,
   // and the counters wrap on that same edge, so there is no gap cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_cnt    <= '0;
         sam_cnt    <= '0;
         sam_clk_en <= 1'b0;
         sym_clk_en <= 1'b0;
      end else begin
         sam_clk_en <= clk_last;
         sym_clk_en <= clk_last && sam_last;
         if (clk_last) begin
            clk_cnt <= '0;
            sam_cnt <= sam_last ? '0 : sam_cnt + 1'b1;
         end else begin
            clk_cnt <= clk_cnt + 1'b1;
         end
      end
   end

   prbs_lfsr22 #(
      .SEED    (LFSR_SEED_P)
   ) u_prbs (
      .clk     (clk),
      .reset   (reset),
      .advance (lfsr_adv),
      .state   (lfsr_state)
   );

   // A zero register state is being forced to 1 on this edge; draw the
   // symbol that the forced state would supply.
   assign prbs_sym = (lfsr_state == 22'h000000) ? 2'b01 : lfsr_state[1:0];

   // sw is taken as the mode of the symbol launched on this sym_clk_en edge
   // and held in `mode` for the rest of that symbol. x_out only changes on
   // enable edges, so a mid-symbol sw change cannot disturb the symbol in
   // flight; it takes effect at the next symbol boundary.
   assign sym_mode = mode_t'(sw);

   always_comb begin
      sym_sel    = SYM_P3A;
      lfsr_adv   = 1'b0;
      level_zero = 1'b0;
      unique case (sym_mode)
         MODE_PRBS: begin
            sym_sel  = prbs_sym;
            lfsr_adv = sym_clk_en;
         end
         MODE_CONST: begin
            sym_sel = SYM_P3A;
         end
         MODE_ALT: begin
            sym_sel = alt_phase ? SYM_M3A : SYM_P3A;
         end
         MODE_IMP: begin
            // Only the first symbol after entering the mode carries the pulse.
            sym_sel    = SYM_P3A;
            level_zero = impulse_done && (mode == MODE_IMP);
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mode         <= MODE_PRBS;
         impulse_done <= 1'b0;
         alt_phase    <= 1'b0;
         x_out        <= '0;
         sym_out      <= '0;
      end else if (sym_clk_en) begin
         mode         <= sym_mode;
         impulse_done <= (sym_mode == MODE_IMP);
         // Phase restarts whenever the alternating pattern is re-entered,
         // so it always opens with +3a.
         alt_phase    <= (sym_mode == MODE_ALT) ? ~alt_phase : 1'b0;
         x_out        <= level_zero ? 18'sd0 : gray_level(sym_sel, LEVEL_A_P, LEVEL_3A_P);
         sym_out      <= sym_sel;
      end else if (sam_clk_en) begin
         x_out <= '0;
      end
   end

endmodule

// File: tb/tb_ask4_symbol_source.sv
// tb_ask4_symbol_source
//   Self-checking bench for ask4_symbol_source. A reference model counts
//   clock edges since reset release and derives enables, symbols and x_out
//   from the edge index with plain arithmetic.
module tb_ask4_symbol_source;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [1:0]         sw = 2'b00;
   logic               sam_clk_en;
   logic               sym_clk_en;
   logic signed [17:0] x_out;
   logic [1:0]         sym_out;

   int checks = 0;
   int failures = 0;
   int n = -1;

   logic [21:0]        m_lfsr;
   int                 m_alt;
   bit                 m_imp;
   logic               exp_sam;
   logic               exp_sym;
   logic signed [17:0] exp_x;
   logic [1:0]         exp_so;
   logic [17:0]        exp_q[$];

   always #5 clk = ~clk;

   ask4_symbol_source dut (
      .clk        (clk),
      .reset      (reset),
      .sw         (sw),
      .sam_clk_en (sam_clk_en),
      .sym_clk_en (sym_clk_en),
      .x_out      (x_out),
      .sym_out    (sym_out)
   );

   task automatic model_reset();
      m_lfsr  = 22'h000001;
      m_alt   = 0;
      m_imp   = 1'b0;
      exp_sam = 1'b0;
      exp_sym = 1'b0;
      exp_x   = '0;
      exp_so  = '0;
      n       = -1;
   endtask

   task automatic do_reset(input logic [1:0] mode);
      @(negedge clk);
      reset = 1'b1;
      sw    = mode;
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One clock edge; the model works from the edge index n (0 = first edge
   // after release): sample pulses at n%4==3, symbol pulses at n%16==15, a
   // new symbol lands on x_out one edge after each symbol pulse and is
   // cleared one edge after the next sample pulse.
   task automatic step();
      int lv[4] = '{-49152, -16384, 49152, 16384};
      logic [1:0] s;
      bit zero;
      @(posedge clk);
      n++;
      exp_sam = (n % 4 == 3);
      exp_sym = (n % 16 == 15);
      if (n >= 16 && n % 16 == 0) begin
         zero = 1'b0;
         s    = 2'b10;
         case (sw)
            2'd0: begin
               s = m_lfsr[1:0];
               m_lfsr = (m_lfsr << 1) | (((m_lfsr >> 21) ^ (m_lfsr >> 20)) & 22'd1);
            end
            2'd1: s = 2'b10;
            2'd2: begin
               s = (m_alt % 2 == 0) ? 2'b10 : 2'b00;
               m_alt++;
            end
            default: begin
               s = 2'b10;
               zero = m_imp;
               m_imp = 1'b1;
            end
         endcase
         if (sw != 2'd2) m_alt = 0;
         if (sw != 2'd3) m_imp = 1'b0;
         exp_x  = zero ? 18'sd0 : 18'(lv[s]);
         exp_so = s;
      end else if (n >= 4 && n % 4 == 0) begin
         exp_x = '0;
      end
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1'b1;
      sw = 2'b00;
      model_reset();
      #1;
      checks++;
      if ({sam_clk_en, sym_clk_en, x_out, sym_out} !== 22'd0) begin
         failures++;
         $display("FAIL reset_state got sam=%b sym=%b x=%0d so=%b expected all 0",
                  sam_clk_en, sym_clk_en, x_out, sym_out);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_enables();
      do_reset(2'b00);
      repeat (48) begin
         step();
         checks++;
         if ({sam_clk_en, sym_clk_en, x_out, sym_out} !== {exp_sam, exp_sym, exp_x, exp_so}) begin
            failures++;
            $display("FAIL enables n=%0d got sam=%b sym=%b x=%0d so=%b expected sam=%b sym=%b x=%0d so=%b",
                     n, sam_clk_en, sym_clk_en, x_out, sym_out, exp_sam, exp_sym, exp_x, exp_so);
         end
      end
   endtask

   task automatic test_const();
      do_reset(2'b01);
      repeat (64) begin
         step();
         checks++;
         if ({sam_clk_en, sym_clk_en, x_out, sym_out} !== {exp_sam, exp_sym, exp_x, exp_so}) begin
            failures++;
            $display("FAIL const n=%0d got sam=%b sym=%b x=%0d so=%b expected sam=%b sym=%b x=%0d so=%b",
                     n, sam_clk_en, sym_clk_en, x_out, sym_out, exp_sam, exp_sym, exp_x, exp_so);
         end
      end
      checks++;
      if (sym_out !== 2'b10) begin
         failures++;
         $display("FAIL const_sym got %b expected 10", sym_out);
      end
   endtask

   task automatic test_alt();
      do_reset(2'b10);
      repeat (96) begin
         step();
         checks++;
         if ({sam_clk_en, sym_clk_en, x_out, sym_out} !== {exp_sam, exp_sym, exp_x, exp_so}) begin
            failures++;
            $display("FAIL alt n=%0d got sam=%b sym=%b x=%0d so=%b expected sam=%b sym=%b x=%0d so=%b",
                     n, sam_clk_en, sym_clk_en, x_out, sym_out, exp_sam, exp_sym, exp_x, exp_so);
         end
      end
   endtask

   task automatic test_prbs();
      logic [17:0] want;
      do_reset(2'b00);
      exp_q.push_back(-18'sd16384);
      exp_q.push_back(18'sd49152);
      exp_q.push_back(-18'sd49152);
      repeat (48) begin
         step();
         if (n % 16 == 0 && n >= 16 && exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (x_out !== want) begin
               failures++;
               $display("FAIL prbs_seq n=%0d got x=%0d expected %0d", n, x_out, $signed(want));
            end
         end
      end
   endtask

   task automatic test_impulse();
      do_reset(2'b00);
      while (n < 112) begin
         step();
         checks++;
         if ({sam_clk_en, sym_clk_en, x_out, sym_out} !== {exp_sam, exp_sym, exp_x, exp_so}) begin
            failures++;
            $display("FAIL impulse n=%0d got sam=%b sym=%b x=%0d so=%b expected sam=%b sym=%b x=%0d so=%b",
                     n, sam_clk_en, sym_clk_en, x_out, sym_out, exp_sam, exp_sym, exp_x, exp_so);
         end
         if (n == 32 || n == 96) begin
            checks++;
            if (x_out !== 18'sd49152) begin
               failures++;
               $display("FAIL impulse_peak n=%0d got x=%0d expected 49152", n, x_out);
            end
         end
         if (n == 48 || n == 64) begin
            checks++;
            if (x_out !== 18'sd0) begin
               failures++;
               $display("FAIL impulse_tail n=%0d got x=%0d expected 0", n, x_out);
            end
         end
         if (n == 20 || n == 70 || n == 84) begin
            @(negedge clk);
            sw = (n == 70) ? 2'b00 : 2'b11;
         end
      end
   endtask

   task automatic test_reset_mid(input int k);
      do_reset(2'b01);
      while (n < k) step();
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({sam_clk_en, sym_clk_en, x_out, sym_out} !== 22'd0) begin
         failures++;
         $display("FAIL reset_mid_%0d got sam=%b sym=%b x=%0d so=%b expected all 0",
                  k, sam_clk_en, sym_clk_en, x_out, sym_out);
      end
      model_reset();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (48) begin
         step();
         checks++;
         if ({sam_clk_en, sym_clk_en, x_out, sym_out} !== {exp_sam, exp_sym, exp_x, exp_so}) begin
            failures++;
            $display("FAIL reset_rerun n=%0d got sam=%b sym=%b x=%0d so=%b expected sam=%b sym=%b x=%0d so=%b",
                     n, sam_clk_en, sym_clk_en, x_out, sym_out, exp_sam, exp_sym, exp_x, exp_so);
         end
      end
   endtask

   task automatic test_random();
      do_reset(2'($urandom_range(0, 3)));
      repeat (800) begin
         step();
         checks++;
         if ({sam_clk_en, sym_clk_en, x_out, sym_out} !== {exp_sam, exp_sym, exp_x, exp_so}) begin
            failures++;
            $display("FAIL random n=%0d sw=%b got sam=%b sym=%b x=%0d so=%b expected sam=%b sym=%b x=%0d so=%b",
                     n, sw, sam_clk_en, sym_clk_en, x_out, sym_out, exp_sam, exp_sym, exp_x, exp_so);
         end
         if ($urandom_range(0, 19) == 0) begin
            @(negedge clk);
            sw = 2'($urandom_range(0, 3));
         end
      end
   endtask

   initial begin
      test_reset();
      test_enables();
      test_const();
      test_alt();
      test_prbs();
      test_impulse();
      test_reset_mid(21);
      test_reset_mid(15);
      test_reset_mid(16);
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
